// File: rtl/sdram_bus_monitor.sv
// rtl/sdram_bus_monitor.sv - passive SDR SDRAM pin monitor: command decode, bank/timing checks, beat capture
module sdram_bus_monitor #(
   parameter int SDR_DW    = 16,
   parameter int SDR_BW    = 2,
   parameter int SDR_AW    = 13,
   parameter int SDR_BAW   = 2,
   parameter int COL_W     = 9,
   parameter int CAS_LAT   = 3,
   parameter int BURST_LEN = 4,
   parameter int T_RCD     = 3,
   parameter int T_RP      = 3,
   parameter int T_RAS     = 6,
   parameter int T_MRD     = 2
) (
   input  logic                      sdram_clk,
   input  logic                      sdram_resetn,
   input  logic                      sdr_cke,
   input  logic                      sdr_cs_n,
   input  logic                      sdr_ras_n,
   input  logic                      sdr_cas_n,
   input  logic                      sdr_we_n,
   input  logic [SDR_BAW-1:0]        sdr_ba,
   input  logic [SDR_AW-1:0]         sdr_addr,
   input  logic [SDR_BW-1:0]         sdr_dqm,
   input  logic [SDR_DW-1:0]         sdr_dq,
   input  logic                      sdr_init_done,
   output logic                      cmd_valid,
   output logic [2:0]                cmd_code,
   output logic [SDR_BAW-1:0]        cmd_bank,
   output logic [SDR_AW-1:0]         cmd_addr,
   output logic [(2**SDR_BAW)-1:0]   bank_open,
   output logic                      rd_valid,
   output logic [SDR_DW-1:0]         rd_data,
   output logic [SDR_BW-1:0]         rd_mask,
   output logic                      wr_valid,
   output logic [SDR_DW-1:0]         wr_data,
   output logic [SDR_BW-1:0]         wr_mask,
   output logic                      err_valid,
   output logic [3:0]                err_code,
   output logic [15:0]               err_count
);
   localparam int NUM_BANKS = 2**SDR_BAW;
   localparam int RS_W      = CAS_LAT + BURST_LEN - 1;

   localparam logic [2:0] CMD_NOP = 3'd0;
   localparam logic [2:0] CMD_ACT = 3'd1;
   localparam logic [2:0] CMD_RD  = 3'd2;
   localparam logic [2:0] CMD_WR  = 3'd3;
   localparam logic [2:0] CMD_PRE = 3'd4;
   localparam logic [2:0] CMD_REF = 3'd5;
   localparam logic [2:0] CMD_MRS = 3'd6;
   localparam logic [2:0] CMD_BST = 3'd7;

   localparam logic [7:0] RCD_LIM = 8'(T_RCD - 1);
   localparam logic [7:0] RP_LIM  = 8'(T_RP - 1);
   localparam logic [7:0] RAS_LIM = 8'(T_RAS - 1);
   localparam logic [7:0] MRD_LIM = 8'(T_MRD - 1);
   localparam logic [7:0] RD_AP   = 8'(CAS_LAT + BURST_LEN - 1);
   localparam logic [7:0] WR_AP   = 8'(BURST_LEN - 1);
   localparam logic [3:0] WR_LOAD = 4'(BURST_LEN - 1);

   // rd_sched bit i marks a read beat due i+1 edges from now
   localparam logic [RS_W-1:0] RD_NEW   = RS_W'({BURST_LEN{1'b1}}) << (CAS_LAT - 1);
   localparam logic [RS_W-1:0] KEEP_RD  = RS_W'((1 << (CAS_LAT - 1)) - 1);
   localparam logic [RS_W-1:0] KEEP_BST = RS_W'((1 << (CAS_LAT - 2)) - 1);

   // column bits must sit below the A10 auto-precharge bit
   generate
      if (COL_W > 10 || CAS_LAT < 2 || CAS_LAT > 3) begin : g_bad_param
         $error("sdram_bus_monitor: unsupported COL_W or CAS_LAT");
      end
   endgenerate

   logic [2:0]  dec_code;
   logic        dec_valid;
   logic        is_act, is_rd, is_wr, is_pre, is_bst;
   logic [7:1]  e_flags;
   logic [3:0]  e_code;
   logic [7:0]  act_tmr [NUM_BANKS];
   logic [7:0]  pre_tmr [NUM_BANKS];
   logic [7:0]  ap_cnt  [NUM_BANKS];
   logic [NUM_BANKS-1:0] ap_pend;
   logic [7:0]  mrs_tmr;
   logic [RS_W-1:0] rd_sched, rd_shift;
   logic [SDR_BW-1:0] dqm_d1, dqm_d2;
   logic [3:0]  wr_left;
   logic        wr_beat;

   always_comb begin
      dec_code = CMD_NOP;
      case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
         3'b011:  dec_code = CMD_ACT;
         3'b101:  dec_code = CMD_RD;
         3'b100:  dec_code = CMD_WR;
         3'b010:  dec_code = CMD_PRE;
         3'b001:  dec_code = CMD_REF;
         3'b000:  dec_code = CMD_MRS;
         3'b110:  dec_code = CMD_BST;
         default: dec_code = CMD_NOP;
      endcase
   end

   assign dec_valid = sdr_cke && !sdr_cs_n && (dec_code != CMD_NOP);
   assign is_act    = dec_valid && (dec_code == CMD_ACT);
   assign is_rd     = dec_valid && (dec_code == CMD_RD);
   assign is_wr     = dec_valid && (dec_code == CMD_WR);
   assign is_pre    = dec_valid && (dec_code == CMD_PRE);
   assign is_bst    = dec_valid && (dec_code == CMD_BST);

   // checks see the bank state as it was before this command
   always_comb begin
      e_flags = '0;
      e_code  = '0;
      if (dec_valid && sdr_init_done) begin
         case (dec_code)
            CMD_RD, CMD_WR: begin
               if (!bank_open[sdr_ba]) e_flags[1] = 1'b1;
               if (act_tmr[sdr_ba] < RCD_LIM) e_flags[3] = 1'b1;
            end
            CMD_ACT: begin
               if (bank_open[sdr_ba]) e_flags[2] = 1'b1;
               if (pre_tmr[sdr_ba] < RP_LIM) e_flags[4] = 1'b1;
            end
            CMD_PRE: begin
               for (int b = 0; b < NUM_BANKS; b++)
                  if ((sdr_addr[10] || sdr_ba == SDR_BAW'(b)) && bank_open[b] && act_tmr[b] < RAS_LIM)
                     e_flags[5] = 1'b1;
            end
            CMD_REF: if (|bank_open) e_flags[6] = 1'b1;
            default: ;
         endcase
         if (mrs_tmr < MRD_LIM) e_flags[7] = 1'b1;
      end
      for (int i = 7; i >= 1; i--)
         if (e_flags[i]) e_code = 4'(i);
   end

   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         cmd_valid <= 1'b0;
         cmd_code  <= CMD_NOP;
         cmd_bank  <= '0;
         cmd_addr  <= '0;
         err_valid <= 1'b0;
         err_code  <= '0;
         err_count <= '0;
      end else begin
         cmd_valid <= dec_valid;
         cmd_code  <= dec_valid ? dec_code : CMD_NOP;
         cmd_bank  <= sdr_ba;
         cmd_addr  <= sdr_addr;
         err_valid <= |e_flags;
         err_code  <= e_code;
         if (|e_flags && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
   end

   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         bank_open <= '0;
         ap_pend   <= '0;
         mrs_tmr   <= 8'hFF;
         for (int b = 0; b < NUM_BANKS; b++) begin
            act_tmr[b] <= 8'hFF;
            pre_tmr[b] <= 8'hFF;
            ap_cnt[b]  <= '0;
         end
      end else begin
         mrs_tmr <= (mrs_tmr == 8'hFF) ? mrs_tmr : mrs_tmr + 8'd1;
         if (dec_valid && dec_code == CMD_MRS) mrs_tmr <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            act_tmr[b] <= (act_tmr[b] == 8'hFF) ? act_tmr[b] : act_tmr[b] + 8'd1;
            pre_tmr[b] <= (pre_tmr[b] == 8'hFF) ? pre_tmr[b] : pre_tmr[b] + 8'd1;
            if (ap_pend[b]) begin
               ap_cnt[b] <= ap_cnt[b] - 8'd1;
               if (ap_cnt[b] == 8'd1) begin
                  ap_pend[b]   <= 1'b0;
                  bank_open[b] <= 1'b0;
               end
            end
            if (is_pre && (sdr_addr[10] || sdr_ba == SDR_BAW'(b))) begin
               bank_open[b] <= 1'b0;
               pre_tmr[b]   <= '0;
               ap_pend[b]   <= 1'b0;
            end
         end
         if (is_act) begin
            bank_open[sdr_ba] <= 1'b1;
            act_tmr[sdr_ba]   <= '0;
            ap_pend[sdr_ba]   <= 1'b0;
         end
         // auto-precharge closes the bank on the edge of the burst's last beat
         if (is_rd && sdr_addr[10]) begin
            ap_pend[sdr_ba] <= 1'b1;
            ap_cnt[sdr_ba]  <= RD_AP;
         end
         if (is_wr && sdr_addr[10]) begin
            if (WR_AP == 8'd0) bank_open[sdr_ba] <= 1'b0;
            else begin
               ap_pend[sdr_ba] <= 1'b1;
               ap_cnt[sdr_ba]  <= WR_AP;
            end
         end
      end
   end

   assign rd_shift = rd_sched >> 1;

   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         rd_sched <= '0;
         dqm_d1   <= '0;
         dqm_d2   <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_mask  <= '0;
      end else begin
         dqm_d1   <= sdr_dqm;
         dqm_d2   <= dqm_d1;
         rd_valid <= rd_sched[0];
         rd_data  <= rd_sched[0] ? sdr_dq : '0;
         rd_mask  <= rd_sched[0] ? dqm_d2 : '0;
         if (is_rd)                rd_sched <= (rd_shift & KEEP_RD) | RD_NEW;
         else if (is_bst || is_wr) rd_sched <= rd_shift & KEEP_BST;
         else                      rd_sched <= rd_shift;
      end
   end

   assign wr_beat = is_wr || (wr_left != 4'd0 && !(is_rd || is_bst || is_pre));

   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         wr_left  <= '0;
         wr_valid <= 1'b0;
         wr_data  <= '0;
         wr_mask  <= '0;
      end else begin
         wr_valid <= wr_beat;
         wr_data  <= wr_beat ? sdr_dq : '0;
         wr_mask  <= wr_beat ? sdr_dqm : '0;
         if (is_wr)                         wr_left <= WR_LOAD;
         else if (is_rd || is_bst || is_pre) wr_left <= '0;
         else if (wr_left != 4'd0)          wr_left <= wr_left - 4'd1;
      end
   end
endmodule

// File: tb/tb_sdram_bus_monitor.sv
// tb/tb_sdram_bus_monitor.sv - directed and randomized bench for sdram_bus_monitor with edge-timestamp model
module tb_sdram_bus_monitor;
   localparam int NB = 4, CL = 3, BL = 4, TRCD = 3, TRP = 3, TRAS = 6, TMRD = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, cke, cs_n, ras_n, cas_n, we_n, init_done;
   logic [1:0] ba, dqm;
   logic [12:0] addr;
   logic [15:0] dq;
   logic cmd_valid, rd_valid, wr_valid, err_valid;
   logic [2:0] cmd_code;
   logic [1:0] cmd_bank, rd_mask, wr_mask;
   logic [12:0] cmd_addr;
   logic [3:0] bank_open, err_code;
   logic [15:0] rd_data, wr_data, err_count;

   sdram_bus_monitor #(
      .SDR_DW(16), .SDR_BW(2), .SDR_AW(13), .SDR_BAW(2), .COL_W(9), .CAS_LAT(CL),
      .BURST_LEN(BL), .T_RCD(TRCD), .T_RP(TRP), .T_RAS(TRAS), .T_MRD(TMRD)
   ) dut (
      .sdram_clk(clk), .sdram_resetn(rst_n), .sdr_cke(cke), .sdr_cs_n(cs_n),
      .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n), .sdr_ba(ba),
      .sdr_addr(addr), .sdr_dqm(dqm), .sdr_dq(dq), .sdr_init_done(init_done),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
      .bank_open(bank_open), .rd_valid(rd_valid), .rd_data(rd_data), .rd_mask(rd_mask),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_mask(wr_mask), .err_valid(err_valid),
      .err_code(err_code), .err_count(err_count)
   );

   int checks = 0;
   int errors = 0;

   // model: every event remembered as the edge number it happened on
   int e = 0;
   int act_e[NB], pre_e[NB], close_at[NB];
   int mrs_e, wr_last;
   bit open_m[NB];
   int rd_q[$];
   logic [1:0] dqm_at[int];
   bit x_cmd_valid, x_rd_valid, x_wr_valid, x_err_valid;
   int x_cmd_code, x_bank, x_addr, x_rd_data, x_rd_mask, x_wr_data, x_wr_mask, x_err_code, x_err_count;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic int tmr(input int now, input int ev);
      int d = now - ev - 1;
      return (d > 255) ? 255 : d;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin
         act_e[b] = -1000; pre_e[b] = -1000; close_at[b] = -1; open_m[b] = 0;
      end
      mrs_e = -1000; wr_last = -1000; rd_q.delete(); dqm_at.delete(); x_err_count = 0;
   endtask

   task automatic model_edge();
      int code, b0, lim;
      bit valid;
      bit [7:1] fl;
      int keep[$];
      e++;
      dqm_at[e] = dqm;
      b0 = int'(ba);
      case ({ras_n, cas_n, we_n})
         3'b011: code = 1; 3'b101: code = 2; 3'b100: code = 3; 3'b010: code = 4;
         3'b001: code = 5; 3'b000: code = 6; 3'b110: code = 7; default: code = 0;
      endcase
      valid = cke && !cs_n && code != 0;
      fl = '0;
      if (valid && init_done) begin
         if ((code == 2 || code == 3) && !open_m[b0]) fl[1] = 1;
         if ((code == 2 || code == 3) && tmr(e, act_e[b0]) < TRCD - 1) fl[3] = 1;
         if (code == 1 && open_m[b0]) fl[2] = 1;
         if (code == 1 && tmr(e, pre_e[b0]) < TRP - 1) fl[4] = 1;
         if (code == 4)
            for (int b = 0; b < NB; b++)
               if ((addr[10] || b == b0) && open_m[b] && tmr(e, act_e[b]) < TRAS - 1) fl[5] = 1;
         if (code == 5)
            for (int b = 0; b < NB; b++) if (open_m[b]) fl[6] = 1;
         if (tmr(e, mrs_e) < TMRD - 1) fl[7] = 1;
      end
      x_err_valid = |fl;
      x_err_code = 0;
      for (int i = 1; i <= 7; i++) if (fl[i] && x_err_code == 0) x_err_code = i;
      if (x_err_valid && x_err_count < 65535) x_err_count++;
      x_cmd_valid = valid; x_cmd_code = valid ? code : 0; x_bank = b0; x_addr = int'(addr);
      // read beats: due edges kept in a queue
      x_rd_valid = 0;
      foreach (rd_q[i]) if (rd_q[i] == e) x_rd_valid = 1;
      x_rd_data = int'(dq);
      x_rd_mask = dqm_at.exists(e - 2) ? int'(dqm_at[e - 2]) : 0;
      lim = 1 << 30;
      if (valid && code == 2) lim = e + CL;
      if (valid && (code == 7 || code == 3)) lim = e + CL - 1;
      foreach (rd_q[i]) if (rd_q[i] > e && rd_q[i] < lim) keep.push_back(rd_q[i]);
      rd_q = keep;
      if (valid && code == 2) for (int k = 0; k < BL; k++) rd_q.push_back(e + CL + k);
      // write beats
      if (valid && code == 3) begin
         wr_last = e + BL - 1; x_wr_valid = 1;
      end else if (valid && (code == 2 || code == 7 || code == 4)) begin
         wr_last = e - 1; x_wr_valid = 0;
      end else x_wr_valid = (e <= wr_last);
      x_wr_data = int'(dq); x_wr_mask = int'(dqm);
      // bank state
      for (int b = 0; b < NB; b++)
         if (close_at[b] == e) begin open_m[b] = 0; close_at[b] = -1; end
      if (valid && code == 4)
         for (int b = 0; b < NB; b++)
            if (addr[10] || b == b0) begin open_m[b] = 0; pre_e[b] = e; close_at[b] = -1; end
      if (valid && code == 1) begin open_m[b0] = 1; act_e[b0] = e; close_at[b0] = -1; end
      if (valid && code == 2 && addr[10]) close_at[b0] = e + CL + BL - 1;
      if (valid && code == 3 && addr[10]) close_at[b0] = e + BL - 1;
      if (valid && code == 6) mrs_e = e;
   endtask

   task automatic compare_all();
      logic [3:0] xo;
      for (int b = 0; b < NB; b++) xo[b] = open_m[b];
      chk("cmd_valid", 32'(cmd_valid), 32'(x_cmd_valid));
      chk("cmd_code", 32'(cmd_code), 32'(x_cmd_code));
      if (x_cmd_valid) begin
         chk("cmd_bank", 32'(cmd_bank), 32'(x_bank));
         chk("cmd_addr", 32'(cmd_addr), 32'(x_addr));
      end
      chk("bank_open", 32'(bank_open), 32'(xo));
      chk("rd_valid", 32'(rd_valid), 32'(x_rd_valid));
      if (x_rd_valid) begin
         chk("rd_data", 32'(rd_data), 32'(x_rd_data));
         chk("rd_mask", 32'(rd_mask), 32'(x_rd_mask));
      end
      chk("wr_valid", 32'(wr_valid), 32'(x_wr_valid));
      if (x_wr_valid) begin
         chk("wr_data", 32'(wr_data), 32'(x_wr_data));
         chk("wr_mask", 32'(wr_mask), 32'(x_wr_mask));
      end
      chk("err_valid", 32'(err_valid), 32'(x_err_valid));
      chk("err_code", 32'(err_code), 32'(x_err_code));
      chk("err_count", 32'(err_count), 32'(x_err_count));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive(input int c, input int b, input int a);
      cke = 1'b1; cs_n = 1'b0; ba = 2'(b); addr = 13'(a);
      case (c)
         1: {ras_n, cas_n, we_n} = 3'b011;
         2: {ras_n, cas_n, we_n} = 3'b101;
         3: {ras_n, cas_n, we_n} = 3'b100;
         4: {ras_n, cas_n, we_n} = 3'b010;
         5: {ras_n, cas_n, we_n} = 3'b001;
         6: {ras_n, cas_n, we_n} = 3'b000;
         7: {ras_n, cas_n, we_n} = 3'b110;
         default: {ras_n, cas_n, we_n} = 3'b111;
      endcase
   endtask

   task automatic go(input int c, input int b, input int a);
      drive(c, b, a);
      dq = 16'($urandom);
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) go(0, 0, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
      chk({tag, "_bank_open"}, 32'(bank_open), 32'd0);
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
      chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
      chk({tag, "_err_valid"}, 32'(err_valid), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   initial begin
      int r;
      rst_n = 1'b0; init_done = 1'b0; dqm = '0; dq = '0;
      drive(0, 0, 0);
      cs_n = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      init_done = 1'b1;

      // ACT b0, RD at ACT+3: clean four-beat read
      go(1, 0, 'h1A5); idle(2); go(2, 0, 'h010); idle(8);
      // RD one cycle after ACT: tRCD, then silent with init_done low
      go(1, 1, 'h020); go(2, 1, 'h008); idle(6);
      init_done = 1'b0;
      go(4, 1, 0); idle(3); go(1, 1, 0); go(2, 1, 0); idle(6);
      init_done = 1'b1;
      // tRAS on early PRE, then tRP on early ACT
      go(1, 2, 'h033); idle(1); go(4, 2, 0); go(1, 2, 'h034); idle(3);
      // write burst with a masked third beat
      go(1, 3, 'h010); idle(2);
      drive(3, 3, 0); dq = 16'h1111; dqm = 2'b00; step();
      drive(0, 0, 0); dq = 16'h2222; step();
      dq = 16'h3333; dqm = 2'b10; step();
      dq = 16'h4444; dqm = 2'b00; step();
      idle(3);
      // read cut short by BST, then precharge-all
      idle(4); go(2, 0, 0); idle(1); go(7, 0, 0); idle(8);
      go(4, 0, 'h400); idle(2);
      // async reset in the middle of a read burst
      go(1, 0, 5); idle(2); go(2, 0, 0); idle(4);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      model_reset();
      @(posedge clk);
      #1;
      chk("midreset_hold_rd_valid", 32'(rd_valid), 32'd0);
      rst_n = 1'b1;
      idle(4);
      go(1, 0, 6); idle(3);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 99);
         if (r < 35)      drive(0, 0, 0);
         else if (r < 47) drive(1, $urandom_range(0, 3), $urandom_range(0, 8191));
         else if (r < 59) drive(2, $urandom_range(0, 3), $urandom_range(0, 8191));
         else if (r < 69) drive(3, $urandom_range(0, 3), $urandom_range(0, 8191));
         else if (r < 77) drive(4, $urandom_range(0, 3), $urandom_range(0, 8191));
         else if (r < 81) drive(5, 0, 0);
         else if (r < 86) drive(7, 0, 0);
         else if (r < 88) drive(6, 0, $urandom_range(0, 8191));
         else if (r < 94) begin
            drive($urandom_range(1, 7), 0, 0); cs_n = 1'b1;
         end else begin
            drive($urandom_range(1, 7), $urandom_range(0, 3), 0); cke = 1'b0;
         end
         init_done = ($urandom_range(0, 9) != 0);
         dqm = 2'($urandom);
         dq = 16'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
